// File: rtl/mantissa_sub_norm_pkg.sv
// Shared constants and the controller state type for the mantissa subtract/normalise block.
package mantissa_sub_norm_pkg;

    localparam int MANT_W  = 24;
    localparam int SHAMT_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        SUB,
        NORM,
        DONE
    } state_t;

endpackage

// File: rtl/mantissa_sub_norm_sub_24b.sv
// Unsigned mantissa subtractor: difference plus a borrow that flags b > a.
module sub_24b
    import mantissa_sub_norm_pkg::*;
#(
    parameter int MANT_W = mantissa_sub_norm_pkg::MANT_W
) (
    input  logic [MANT_W-1:0] i_a,
    input  logic [MANT_W-1:0] i_b,
    output logic [MANT_W-1:0] o_diff,
    output logic              o_borrow
);

    always_comb begin
        {o_borrow, o_diff} = {1'b0, i_a} - {1'b0, i_b};
    end

endmodule

// File: rtl/mantissa_sub_norm.sv
// Subtracts two mantissas and left-justifies |a-b|, reporting shift count, sign and zero.
// Define MSN_FAST_NORM_EN to let NORM skip four leading zeros per cycle.
module mantissa_sub_norm
    import mantissa_sub_norm_pkg::*;
#(
    parameter int MANT_W = mantissa_sub_norm_pkg::MANT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [MANT_W-1:0]  a,
    input  logic [MANT_W-1:0]  b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [MANT_W-1:0]  diff,
    output logic [SHAMT_W-1:0] shamt,
    output logic               sign,
    output logic               zero
);

    state_t              r_state;
    state_t              w_nextState;
    logic [MANT_W-1:0]   r_opA;
    logic [MANT_W-1:0]   r_opB;
    logic [MANT_W-1:0]   r_mag;
    logic [SHAMT_W-1:0]  r_shamt;
    logic                r_sign;
    logic                r_zero;
    logic                r_outValid;
    logic [MANT_W-1:0]   w_subDiff;
    logic                w_borrow;
    logic [MANT_W-1:0]   w_magNew;
    logic [MANT_W-1:0]   w_shifted;
    logic [SHAMT_W-1:0]  w_shamtInc;

    sub_24b #(.MANT_W(MANT_W)) u_sub (
        .i_a      (r_opA),
        .i_b      (r_opB),
        .o_diff   (w_subDiff),
        .o_borrow (w_borrow)
    );

    // A borrow means b > a, so the two's-complement negation gives b - a.
    assign w_magNew = w_borrow ? -w_subDiff : w_subDiff;

`ifdef MSN_FAST_NORM_EN
    logic w_fastSkip;
    assign w_fastSkip = (r_mag[MANT_W-1 -: 4] == 4'd0);
    assign w_shifted  = w_fastSkip ? (r_mag << 4) : (r_mag << 1);
    assign w_shamtInc = w_fastSkip ? SHAMT_W'(4) : SHAMT_W'(1);
`else
    assign w_shifted  = r_mag << 1;
    assign w_shamtInc = SHAMT_W'(1);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: if (in_valid) w_nextState = SUB;
            SUB:  begin
                if (w_magNew == '0 || w_magNew[MANT_W-1]) w_nextState = DONE;
                else                                      w_nextState = NORM;
            end
            NORM: if (w_shifted[MANT_W-1]) w_nextState = DONE;
            DONE: if (r_outValid && out_ready) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (r_state == IDLE);
    end

    // The result is presented one cycle after DONE is entered, so out_ready only counts once valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_opA      <= '0;
            r_opB      <= '0;
            r_mag      <= '0;
            r_shamt    <= '0;
            r_sign     <= 1'b0;
            r_zero     <= 1'b0;
            r_outValid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_opA <= a;
                        r_opB <= b;
                    end
                end
                SUB: begin
                    r_mag   <= w_magNew;
                    r_sign  <= w_borrow;
                    r_zero  <= (w_magNew == '0);
                    r_shamt <= '0;
                end
                NORM: begin
                    r_mag   <= w_shifted;
                    r_shamt <= r_shamt + w_shamtInc;
                end
                DONE: begin
                    if (!r_outValid)    r_outValid <= 1'b1;
                    else if (out_ready) r_outValid <= 1'b0;
                end
                default: r_outValid <= 1'b0;
            endcase
        end
    end

    assign out_valid = r_outValid;
    assign diff      = r_mag;
    assign shamt     = r_shamt;
    assign sign      = r_sign;
    assign zero      = r_zero;

endmodule
